uart_cmd_parser: RTL and testbench

Byte-level command framer that sits directly downstream of the UART receiver. It consumes the receiver's `rx_data`/`rx_rdy` byte strobe and assembles host command frames of the form `header, cmd, len, payload[len], checksum`. It verifies each frame and presents the command code, length and a readable payload buffer to the workstation control logic. It holds the frame until the controller acknowledges it, and reports malformed, overlong, stalled or dropped traffic as one-cycle error pulses.

---
 rtl/uart_cmd_parser.sv | 190 +++++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: frames header/cmd/len/payload/checksum commands from the
// UART byte strobe, holds a verified frame until acked, pulses on errors.
//
// Ports:
//   clk, rst          clock, async active-high reset
//   rx_data, rx_rdy   received byte and its ready strobe (edge = one byte)
//   cmd_valid         frame held, level until cmd_ack
//   cmd_code, cmd_len command byte and payload length of the frame
//   rd_addr, rd_data  combinational payload read port
//   cmd_ack           frame consumed (only seen while cmd_valid)
//   busy              parser not idle
//   chk_err, len_err, tout_err, drop_err  one-cycle error pulses
module uart_cmd_parser #(
  parameter logic [7:0] HEADER  = 8'hAA,
  parameter int         MAX_LEN = 16,
  parameter int         TIMEOUT = 25000,
  localparam int        LW      = $clog2(MAX_LEN + 1),
  localparam int        AW      = $clog2(MAX_LEN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    rx_data,
  input  logic          rx_rdy,
  output logic          cmd_valid,
  output logic [7:0]    cmd_code,
  output logic [LW-1:0] cmd_len,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  input  logic          cmd_ack,
  output logic          busy,
  output logic          chk_err,
  output logic          len_err,
  output logic          tout_err,
  output logic          drop_err
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [7:0] MAXB = 8'(MAX_LEN);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_LEN,
    S_DATA,
    S_CHK,
    S_HOLD
  } state_t;

  state_t        state_q, state_d;
  logic          rdy_q;
  logic [7:0]    code_q, code_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] idx_q, idx_d;
  logic [7:0]    sum_q, sum_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          chk_q, chk_d;
  logic          lerr_q, lerr_d;
  logic          tout_q, tout_d;
  logic          drop_q, drop_d;
  logic          wr_en;
  logic [7:0]    pay_q [MAX_LEN];

  logic acc;
  logic active;
  logic [LW-1:0] idx_nx;

  assign acc    = rx_rdy & ~rdy_q;
  assign active = (state_q == S_CMD) || (state_q == S_LEN) ||
                  (state_q == S_DATA) || (state_q == S_CHK);
  assign idx_nx = idx_q + LW'(1);

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    len_d   = len_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cnt_d   = '0;
    wr_en   = 1'b0;
    chk_d   = 1'b0;
    lerr_d  = 1'b0;
    tout_d  = 1'b0;
    drop_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (acc && rx_data == HEADER) state_d = S_CMD;
      end
      S_CMD: begin
        if (acc) begin
          code_d  = rx_data;
          sum_d   = rx_data;
          state_d = S_LEN;
        end
      end
      S_LEN: begin
        if (acc) begin
          sum_d = sum_q + rx_data;
          if (rx_data > MAXB) begin
            lerr_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            len_d   = rx_data[LW-1:0];
            idx_d   = '0;
            state_d = (rx_data == 8'd0) ? S_CHK : S_DATA;
          end
        end
      end
      S_DATA: begin
        if (acc) begin
          wr_en = 1'b1;
          sum_d = sum_q + rx_data;
          idx_d = idx_nx;
          if (idx_nx == len_q) state_d = S_CHK;
        end
      end
      S_CHK: begin
        if (acc) begin
          if (rx_data == sum_q) begin
            state_d = S_HOLD;
          end else begin
            chk_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_HOLD: begin
        drop_d = acc;
        if (cmd_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // An accepted byte clears the counter (default 0) and beats the timeout.
    if (active && !acc) begin
      if (cnt_q == TLAST) begin
        tout_d  = 1'b1;
        state_d = S_IDLE;
      end else begin
        cnt_d = cnt_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      rdy_q   <= 1'b0;
      code_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      chk_q   <= 1'b0;
      lerr_q  <= 1'b0;
      tout_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= rx_rdy;
      code_q  <= code_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      chk_q   <= chk_d;
      lerr_q  <= lerr_d;
      tout_q  <= tout_d;
      drop_q  <= drop_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_LEN; i++) pay_q[i] <= '0;
    end else if (wr_en) begin
      pay_q[idx_q[AW-1:0]] <= rx_data;
    end
  end

  assign cmd_valid = (state_q == S_HOLD);
  assign busy      = (state_q != S_IDLE);
  assign cmd_code  = code_q;
  assign cmd_len   = len_q;
  assign rd_data   = pay_q[rd_addr];
  assign chk_err   = chk_q;
  assign len_err   = lerr_q;
  assign tout_err  = tout_q;
  assign drop_err  = drop_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser: directed frame-level bench for uart_cmd_parser.
// Drives byte strobes on the falling edge, checks on the falling edge.
module tb_uart_cmd_parser;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_rdy;
  logic       cmd_valid;
  logic [7:0] cmd_code;
  logic [4:0] cmd_len;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic       cmd_ack;
  logic       busy;
  logic       chk_err;
  logic       len_err;
  logic       tout_err;
  logic       drop_err;

  int n_run  = 0;
  int n_fail = 0;
  int n_chk  = 0;
  int n_len  = 0;
  int n_tout = 0;
  int n_drop = 0;

  uart_cmd_parser dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_rdy    (rx_rdy),
    .cmd_valid (cmd_valid),
    .cmd_code  (cmd_code),
    .cmd_len   (cmd_len),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .cmd_ack   (cmd_ack),
    .busy      (busy),
    .chk_err   (chk_err),
    .len_err   (len_err),
    .tout_err  (tout_err),
    .drop_err  (drop_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (chk_err)  n_chk++;
    if (len_err)  n_len++;
    if (tout_err) n_tout++;
    if (drop_err) n_drop++;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input int w);
    @(negedge clk);
    rx_data = b;
    rx_rdy  = 1'b1;
    repeat (w) @(negedge clk);
    rx_rdy  = 1'b0;
  endtask

  task automatic ack();
    @(negedge clk);
    cmd_ack = 1'b1;
    @(negedge clk);
    cmd_ack = 1'b0;
  endtask

  function automatic logic [3:0] errs();
    return {chk_err, len_err, tout_err, drop_err};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int early;
    int base;
    rst     = 1'b1;
    rx_data = 8'h00;
    rx_rdy  = 1'b0;
    cmd_ack = 1'b0;
    rd_addr = 4'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_valid", cmd_valid, 1'b0);
    check("rst_code", cmd_code, 8'h00);
    check("rst_len", cmd_len, 5'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_rd", rd_data, 8'h00);
    check("rst_errs", errs(), 4'h0);

    // valid frame
    send(8'hAA, 1);
    check("hdr_busy", busy, 1'b1);
    send(8'h01, 1);
    send(8'h02, 1);
    send(8'h10, 1);
    send(8'h20, 1);
    check("pre_valid", cmd_valid, 1'b0);
    send(8'h33, 1);
    check("v1_valid", cmd_valid, 1'b1);
    check("v1_code", cmd_code, 8'h01);
    check("v1_len", cmd_len, 5'd2);
    rd_addr = 4'd0;
    #1 check("v1_rd0", rd_data, 8'h10);
    rd_addr = 4'd1;
    #1 check("v1_rd1", rd_data, 8'h20);
    ack();
    check("v1_ack_valid", cmd_valid, 1'b0);
    check("v1_ack_busy", busy, 1'b0);

    // bad checksum
    send(8'hAA, 1);
    send(8'h01, 1);
    send(8'h02, 1);
    send(8'h10, 1);
    send(8'h20, 1);
    send(8'h34, 1);
    check("bad_chk_pulse", chk_err, 1'b1);
    check("bad_chk_valid", cmd_valid, 1'b0);
    check("bad_chk_busy", busy, 1'b0);
    @(negedge clk);
    check("bad_chk_width", chk_err, 1'b0);
    send(8'hAA, 1);
    send(8'h07, 1);
    send(8'h00, 1);
    send(8'h07, 1);
    check("z_valid", cmd_valid, 1'b1);
    check("z_code", cmd_code, 8'h07);
    check("z_len", cmd_len, 5'd0);
    ack();

    // length limit
    send(8'hAA, 1);
    send(8'h03, 1);
    send(8'h11, 1);
    check("len_pulse", len_err, 1'b1);
    check("len_busy", busy, 1'b0);
    @(negedge clk);
    check("len_width", len_err, 1'b0);
    send(8'hAA, 1);
    send(8'h03, 1);
    send(8'h10, 1);
    for (int i = 0; i < 16; i++) send(8'h01, 1);
    send(8'h23, 1);
    check("max_valid", cmd_valid, 1'b1);
    check("max_len", cmd_len, 5'd16);
    rd_addr = 4'd15;
    #1 check("max_rd15", rd_data, 8'h01);

    // hold and drop
    send(8'hAA, 1);
    check("drop_pulse", drop_err, 1'b1);
    check("drop_valid", cmd_valid, 1'b1);
    check("drop_code", cmd_code, 8'h03);
    check("drop_len", cmd_len, 5'd16);
    check("drop_rd", rd_data, 8'h01);
    @(negedge clk);
    check("drop_width", drop_err, 1'b0);
    @(negedge clk);
    cmd_ack = 1'b1;
    rx_data = 8'hAA;
    rx_rdy  = 1'b1;
    @(negedge clk);
    cmd_ack = 1'b0;
    rx_rdy  = 1'b0;
    check("ackdrop_pulse", drop_err, 1'b1);
    check("ackdrop_valid", cmd_valid, 1'b0);
    check("ackdrop_busy", busy, 1'b0);

    // timeout and noise
    send(8'h55, 1);
    check("noise_busy", busy, 1'b0);
    send(8'hAA, 1);
    send(8'h05, 1);
    early = tout_err ? 1 : 0;
    for (int i = 2; i <= 25000; i++) begin
      @(negedge clk);
      if (i < 25000 && tout_err) early++;
      if (i == 24999) check("tout_busy_pre", busy, 1'b1);
    end
    check("tout_early", early, 0);
    check("tout_pulse", tout_err, 1'b1);
    check("tout_busy", busy, 1'b0);
    @(negedge clk);
    check("tout_width", tout_err, 1'b0);

    // wide strobes
    send(8'hAA, 3);
    send(8'h02, 3);
    send(8'h01, 3);
    send(8'h7E, 3);
    send(8'h81, 3);
    check("wide_valid", cmd_valid, 1'b1);
    check("wide_code", cmd_code, 8'h02);
    check("wide_len", cmd_len, 5'd1);
    rd_addr = 4'd0;
    #1 check("wide_rd0", rd_data, 8'h7E);
    ack();

    // reset in DATA
    send(8'hAA, 1);
    send(8'h04, 1);
    send(8'h03, 1);
    send(8'h11, 1);
    send(8'h22, 1);
    check("mid_busy", busy, 1'b1);
    base = n_chk + n_len + n_tout + n_drop;
    rst = 1'b1;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_code", cmd_code, 8'h00);
    check("arst_len", cmd_len, 5'd0);
    check("arst_rd", rd_data, 8'h00);
    check("arst_errs", errs(), 4'h0);
    @(negedge clk);
    rst = 1'b0;
    send(8'h33, 1);
    check("post_noise", busy, 1'b0);
    send(8'hAA, 1);
    send(8'h09, 1);
    send(8'h00, 1);
    send(8'h09, 1);
    check("post_valid", cmd_valid, 1'b1);
    check("post_code", cmd_code, 8'h09);
    check("post_noerr", n_chk + n_len + n_tout + n_drop, base);
    ack();

    check("tot_chk", n_chk, 1);
    check("tot_len", n_len, 1);
    check("tot_tout", n_tout, 1);
    check("tot_drop", n_drop, 2);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
